// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared UART framing constants and state encodings for the BIP report path
//
// Purpose: constants for 8N1 UART framing, the frame-level FSM state set used by
// bip_report_tx and the bit-phase encoding exposed by uart_tx_core.
// Ports: none (package).
package bip_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } frame_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } tx_phase_e;

  function automatic int bytes_for(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - single-byte 8N1 UART transmitter with baud counter
//
// Purpose: shifts one byte out as start bit, 8 data bits LSB first, stop bit;
// every bit is held for exactly CLKS_PER_BIT clocks.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_valid      byte offered; accepted in a cycle where o_ready is high
//   i_data       byte to transmit
//   o_ready      core idle and able to accept a byte this cycle
//   o_tx         serial line, idle high
//   o_last       high in the final clock of the stop bit
//   o_phase      current bit phase (tx_phase_e encoding)
module uart_tx_core
  import bip_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_last,
  output logic [1:0] o_phase
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_BITS - 1);

  tx_phase_e         phase, phase_nxt;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [7:0]        shreg;
  logic              tx_q;
  logic              baud_end;

  assign baud_end = (baud_cnt == BAUD_MAX);

  always_comb begin
    phase_nxt = phase;
    case (phase)
      PH_IDLE:  if (i_valid) phase_nxt = PH_START;
      PH_START: if (baud_end) phase_nxt = PH_DATA;
      PH_DATA:  if (baud_end && (bit_cnt == BIT_MAX)) phase_nxt = PH_STOP;
      PH_STOP:  if (baud_end) phase_nxt = PH_IDLE;
      default:  phase_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_IDLE;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= STOP_BIT;
    end else begin
      // Baud counter runs only while a bit is on the line and restarts at
      // every bit boundary, so it never passes its terminal count.
      if ((phase == PH_IDLE) || baud_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end

      case (phase)
        PH_IDLE: begin
          if (i_valid) begin
            shreg <= i_data;
            tx_q  <= START_BIT;
          end else begin
            tx_q  <= STOP_BIT;
          end
        end
        PH_START: begin
          if (baud_end) begin
            tx_q    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end
        PH_DATA: begin
          if (baud_end) begin
            if (bit_cnt == BIT_MAX) begin
              tx_q <= STOP_BIT;
            end else begin
              tx_q    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: tx_q <= STOP_BIT;
      endcase
    end
  end

  assign o_ready = (phase == PH_IDLE);
  assign o_last  = (phase == PH_STOP) && baud_end;
  assign o_phase = phase;
  assign o_tx    = tx_q;

endmodule

// File: rtl/bip_report_tx.sv
// rtl/bip_report_tx.sv - snapshots BIP results on done and sends them as a framed UART byte stream
//
// Purpose: on a rising edge of i_bip_done (while idle) captures accumulator and
// instruction count, then sends [HEADER] acc bytes MSB first, count bytes MSB
// first, [XOR checksum] as 8N1 UART bytes with a one-clock gap between bytes.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   i_accumulator   BIP accumulator (ACC_W bits)
//   i_inst_count    BIP instruction counter (CNT_W bits)
//   i_bip_done      BIP finished, level signal
//   o_tx            UART serial out, idle high
//   o_busy          frame in progress (capture through the o_sent cycle)
//   o_sent          one-cycle pulse after the last stop bit of a frame
//   o_overrun       sticky until reset: a done edge arrived while not idle
module bip_report_tx
  import bip_pkg::*;
#(
  parameter int         ACC_W        = 16,
  parameter int         CNT_W        = 8,
  parameter int         CLKS_PER_BIT = 868,
  parameter bit         HEADER_EN    = 1'b1,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter bit         CHECKSUM_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] i_accumulator,
  input  logic [CNT_W-1:0] i_inst_count,
  input  logic             i_bip_done,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_sent,
  output logic             o_overrun
);

  localparam int ACC_B   = bytes_for(ACC_W);
  localparam int CNT_B   = bytes_for(CNT_W);
  localparam int PAY_B   = int'(HEADER_EN) + ACC_B + CNT_B;
  localparam int FRAME_B = PAY_B + int'(CHECKSUM_EN);
  localparam int IDX_W   = $clog2(FRAME_B + 1);

  frame_state_e         state, state_nxt;
  logic                 done_prev;
  logic                 trigger;
  logic [ACC_B*8-1:0]   acc_ext, acc_q;
  logic [CNT_B*8-1:0]   cnt_ext, cnt_q;
  logic [PAY_B*8-1:0]   payload;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           chk;
  logic [7:0]           cur_byte;
  logic                 overrun_q;
  logic                 core_valid;
  logic                 core_ready;
  logic                 core_last;
  logic [1:0]           core_phase;

  assign trigger = i_bip_done & ~done_prev;

  always_comb begin
    acc_ext = '0;
    acc_ext[ACC_W-1:0] = i_accumulator;
    cnt_ext = '0;
    cnt_ext[CNT_W-1:0] = i_inst_count;
  end

  // Everything except the checksum, in transmit order from the top byte down.
  always_comb begin
    payload = '0;
    payload[(ACC_B+CNT_B)*8-1:0] = {acc_q, cnt_q};
    if (HEADER_EN) payload[PAY_B*8-1 -: 8] = HEADER;
  end

  // Byte index past the payload selects the running checksum.
  always_comb begin
    cur_byte = chk;
    for (int i = 0; i < PAY_B; i++) begin
      if (idx == IDX_W'(i)) cur_byte = payload[(PAY_B-1-i)*8 +: 8];
    end
  end

  always_comb begin
    state_nxt  = state;
    core_valid = 1'b0;
    o_busy     = (state != S_IDLE);
    o_sent     = 1'b0;
    case (state)
      S_IDLE: if (trigger) state_nxt = S_LOAD;
      S_LOAD: begin
        core_valid = 1'b1;
        if (core_ready) state_nxt = S_START;
      end
      S_START: if (core_phase == PH_DATA) state_nxt = S_DATA;
      S_DATA:  if (core_phase == PH_STOP) state_nxt = S_STOP;
      S_STOP: begin
        if (core_last) begin
          state_nxt = (idx == IDX_W'(FRAME_B)) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        o_sent    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
      overrun_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      idx       <= '0;
      chk       <= '0;
    end else begin
      done_prev <= i_bip_done;
      // Any edge outside IDLE, including the DONE cycle, is dropped and flagged.
      if (trigger && (state != S_IDLE)) overrun_q <= 1'b1;
      if ((state == S_IDLE) && trigger) begin
        acc_q <= acc_ext;
        cnt_q <= cnt_ext;
        idx   <= '0;
        chk   <= '0;
      end
      // Folding the checksum byte into chk after it is handed over is harmless:
      // chk is cleared at the next capture.
      if ((state == S_LOAD) && core_ready) begin
        idx <= idx + IDX_W'(1);
        chk <= chk ^ cur_byte;
      end
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_valid (core_valid),
    .i_data  (cur_byte),
    .o_ready (core_ready),
    .o_tx    (o_tx),
    .o_last  (core_last),
    .o_phase (core_phase)
  );

  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_bip_report_tx.sv
// tb/tb_bip_report_tx.sv - self-checking bench for bip_report_tx
module tb_bip_report_tx;

  localparam int C = 4;

  typedef logic [7:0] bytq_t[$];
  typedef logic [2:0] evq_t[$];   // {tx, busy, sent} per clock

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] acc_a;
  logic [7:0]  cnt_a;
  logic        done_a;
  logic [11:0] acc_b;
  logic [7:0]  cnt_b;
  logic        done_b;
  logic        tx_a, busy_a, sent_a, ovr_a;
  logic        tx_b, busy_b, sent_b, ovr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bip_report_tx #(
    .ACC_W(16), .CNT_W(8), .CLKS_PER_BIT(C),
    .HEADER_EN(1'b1), .HEADER(8'hA5), .CHECKSUM_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .i_accumulator(acc_a), .i_inst_count(cnt_a),
    .i_bip_done(done_a), .o_tx(tx_a), .o_busy(busy_a), .o_sent(sent_a),
    .o_overrun(ovr_a)
  );

  bip_report_tx #(
    .ACC_W(12), .CNT_W(8), .CLKS_PER_BIT(C),
    .HEADER_EN(1'b0), .HEADER(8'hA5), .CHECKSUM_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .i_accumulator(acc_b), .i_inst_count(cnt_b),
    .i_bip_done(done_b), .o_tx(tx_b), .o_busy(busy_b), .o_sent(sent_b),
    .o_overrun(ovr_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Frame content straight from the framing rules.
  function automatic bytq_t frame_bytes(input logic [31:0] acc, input int acc_nb,
                                        input logic [31:0] cnt, input int cnt_nb,
                                        input bit hen, input bit cen);
    bytq_t fr;
    logic [7:0] x;
    if (hen) fr.push_back(8'hA5);
    for (int i = acc_nb - 1; i >= 0; i--) fr.push_back(acc[i*8 +: 8]);
    for (int i = cnt_nb - 1; i >= 0; i--) fr.push_back(cnt[i*8 +: 8]);
    if (cen) begin
      x = 8'h00;
      foreach (fr[k]) x ^= fr[k];
      fr.push_back(x);
    end
    return fr;
  endfunction

  // Per-clock line picture: one gap clock before each byte, 10 bits of C
  // clocks each, then a single sent clock after the final stop bit.
  function automatic evq_t waveform(input bytq_t fr);
    evq_t w;
    logic [9:0] sym;
    w.push_back(3'b110);
    foreach (fr[k]) begin
      sym = {1'b1, fr[k], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int t = 0; t < C; t++) w.push_back({sym[b], 2'b10});
      w.push_back((k == fr.size() - 1) ? 3'b111 : 3'b110);
    end
    return w;
  endfunction

  evq_t       qa, qb;
  bit         prev_a, prev_b, movr_a, movr_b, cur_busy_a, cur_busy_b;
  logic [2:0] ea, eb;

  always @(posedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete();
      prev_a = 1'b0; prev_b = 1'b0; movr_a = 1'b0; movr_b = 1'b0;
    end else begin
      if (done_a && !prev_a) begin
        if (cur_busy_a) movr_a = 1'b1;
        else qa = waveform(frame_bytes({16'h0, acc_a}, 2, {24'h0, cnt_a}, 1, 1'b1, 1'b1));
      end
      if (done_b && !prev_b) begin
        if (cur_busy_b) movr_b = 1'b1;
        else qb = waveform(frame_bytes({20'h0, acc_b}, 2, {24'h0, cnt_b}, 1, 1'b0, 1'b0));
      end
      prev_a = done_a;
      prev_b = done_b;
    end
  end

  always @(negedge clk) begin
    ea = (qa.size() > 0) ? qa.pop_front() : 3'b100;
    eb = (qb.size() > 0) ? qb.pop_front() : 3'b100;
    cur_busy_a = ea[1];
    cur_busy_b = eb[1];
    check("cyc_a tx/busy/sent/ovr", {tx_a, busy_a, sent_a, ovr_a}, {ea, movr_a});
    check("cyc_b tx/busy/sent/ovr", {tx_b, busy_b, sent_b, ovr_b}, {eb, movr_b});
  end

  task automatic wait_sent_a(input string name);
    int n = 0;
    while (sent_a !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    check(name, sent_a, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bytq_t      fr;
    logic [7:0] lit1 [5];
    logic [7:0] lit2 [3];
    int         lat;
    int         nsent;

    rst = 1'b1; done_a = 1'b0; done_b = 1'b0;
    acc_a = '0; cnt_a = '0; acc_b = '0; cnt_b = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_sent", sent_a, 0);
    check("rst_ovr", ovr_a, 0);
    rst = 1'b0;

    // Hand-computed frames pin the model.
    lit1 = '{8'hA5, 8'h12, 8'h34, 8'h05, 8'h86};
    fr = frame_bytes(32'h1234, 2, 32'h05, 1, 1'b1, 1'b1);
    check("pin_len1", fr.size(), 5);
    for (int k = 0; k < 5; k++) check("pin_byte1", fr[k], lit1[k]);
    check("pin_wave_len1", waveform(fr).size(), 206);
    lit2 = '{8'h0A, 8'hBC, 8'hFF};
    fr = frame_bytes(32'hABC, 2, 32'hFF, 1, 1'b0, 1'b0);
    check("pin_len2", fr.size(), 3);
    for (int k = 0; k < 3; k++) check("pin_byte2", fr[k], lit2[k]);

    // 1: default frame; done pulse, then count clocks after the trigger clock
    // until o_sent (trigger clock + 206 = 207).
    @(negedge clk);
    acc_a = 16'h1234; cnt_a = 8'h05; done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    lat = 1;
    while (sent_a !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
    check("t1_sent_latency", lat, 206);
    repeat (3) @(negedge clk);

    // 2: no header, no checksum, 12-bit accumulator.
    acc_b = 12'hABC; cnt_b = 8'hFF; done_b = 1'b1;
    @(negedge clk);
    done_b = 1'b0;
    lat = 0;
    while (sent_b !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
    check("t2_sent_latency", lat, 1 + 3 * (1 + 10 * C) - 1);
    @(negedge clk);
    check("t2_busy_after_done", busy_b, 0);

    // 3: done held high for 500 clocks gives one frame only.
    acc_a = 16'h0F0F; cnt_a = 8'h77; done_a = 1'b1;
    nsent = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sent_a === 1'b1) nsent++;
    end
    done_a = 1'b0;
    check("t3_frames", nsent, 1);
    check("t3_ovr", ovr_a, 0);
    repeat (3) @(negedge clk);

    // 4: second edge mid-frame with a changed accumulator.
    acc_a = 16'hCAFE; cnt_a = 8'h11; done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    repeat (60) @(negedge clk);
    acc_a = 16'hFFFF; done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    wait_sent_a("t4_sent");
    nsent = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sent_a === 1'b1) nsent++;
    end
    check("t4_no_second_frame", nsent, 0);
    check("t4_ovr_sticky", ovr_a, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_ovr_cleared", ovr_a, 0);

    // 5: reset during data bits of the second byte, then a clean frame.
    acc_a = 16'h5A3C; cnt_a = 8'hC3; done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_tx_after_rst", tx_a, 1);
    check("t5_busy_after_rst", busy_a, 0);
    acc_a = 16'hBEEF; cnt_a = 8'h3C; done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    wait_sent_a("t5_sent");

    // 6: edge on the first IDLE clock after o_sent is accepted.
    @(negedge clk);
    acc_a = 16'h0102; cnt_a = 8'h03; done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    check("t6_busy", busy_a, 1);
    wait_sent_a("t6_sent");
    check("t6_ovr", ovr_a, 0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_report_tx.md
Name: bip_report_tx

Overview:
Parametrised successor to the fixed BIP result interface. On each rising edge of the BIP done flag it snapshots the accumulator and instruction count. It then serialises them as a framed byte stream over a UART transmit line (8N1), with an optional header byte and an optional XOR checksum byte. It sits between the BIP core and the board TX pin.

Parameters:
ACC_W, 16, accumulator width in bits (1..32); sent as ACC_B = ceil(ACC_W/8) bytes.
CNT_W, 8, instruction-count width in bits (1..32); sent as CNT_B = ceil(CNT_W/8) bytes.
CLKS_PER_BIT, 868, clk cycles per UART bit (>=2).
HEADER_EN, 1, 1 = prepend header byte.
HEADER, 8'hA5, header byte value.
CHECKSUM_EN, 1, 1 = append XOR of all preceding frame bytes, header included.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_accumulator  in  ACC_W  BIP accumulator
i_inst_count  in  CNT_W  BIP instruction counter
i_bip_done  in  1  BIP finished (level)
o_tx  out  1  UART serial out, idle high
o_busy  out  1  frame in progress
o_sent  out  1  one-cycle pulse after last stop bit of a frame
o_overrun  out  1  sticky: done edge arrived while busy

Behaviour:
- Reset (clk edge with rst=1): o_tx=1, o_busy=0, o_sent=0, o_overrun=0, done_prev=0, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame; o_tx is high from the next cycle.
- Edge detect: trigger = i_bip_done & ~done_prev; done_prev registered every cycle. Because done_prev resets to 0, done held high through reset release gives exactly one trigger.
- Capture: on trigger in IDLE, register acc/count, zero-extended to byte multiples. Later input changes do not affect the frame.
- Frame order: [HEADER], acc bytes MSB first, count bytes MSB first, [checksum]. Length N = HEADER_EN + ACC_B + CNT_B + CHECKSUM_EN.
- FSM states: IDLE -> LOAD -> START -> DATA -> STOP -> (LOAD if bytes remain, else DONE) -> IDLE.
  - LOAD: selects the next byte and updates the checksum; lasts 1 cycle.
  - START, STOP and each of the 8 DATA bits: each lasts exactly CLKS_PER_BIT cycles. DATA is LSB first.
  - DONE: asserts o_sent for 1 cycle.
- Byte gap: 1 clk (the LOAD cycle) between a stop bit and the next start bit.
- Latency: trigger sampled at edge N; o_busy=1 and FSM=LOAD from N+1. o_tx falls (start bit) at N+2.
- Frame duration (trigger to o_sent) = 1 + N*(1 + 10*CLKS_PER_BIT) + 1 cycles.
- o_busy stays high from capture through the DONE cycle; it is low in IDLE only.
- Trigger while not IDLE: ignored (no re-capture) and o_overrun set to 1 until rst.
- Trigger in the same cycle as DONE: ignored and flagged. A trigger on the first IDLE cycle is accepted.
- Checksum is an 8-bit XOR over the bytes actually sent before it.
- Bit counter and baud counter widths: $clog2 of their maxima; no wrap beyond terminal counts.

Decomposition:
- Shared package (bip_pkg): UART frame constants (START=0, STOP=1, DATA_BITS=8) and FSM state enum.
- Sub-module uart_tx_core holds the START/DATA/STOP shift logic and the baud counter.
  - Handshake: i_valid/i_data/o_ready. o_ready is high in the cycle the core is idle.
  - The top FSM supplies bytes and handles framing, checksum and flags.

Test Plan:
1. ACC_W=16, CNT_W=8, CLKS_PER_BIT=4, defaults; acc=16'h1234, cnt=8'h05, pulse done -> o_tx bytes A5,12,34,05,86, each bit 4 cycles LSB first; o_sent after 1+5*41+1=207 cycles.
2. HEADER_EN=0, CHECKSUM_EN=0, ACC_W=12; acc=12'hABC, cnt=8'hFF -> bytes 0A,BC,FF only; o_busy deasserts after DONE.
3. Done held high for 500 cycles -> exactly one frame; o_overrun stays 0.
4. Second done edge mid-frame with acc changed to 16'hFFFF -> first frame unchanged; no second frame; o_overrun=1 until rst.
5. Assert rst during DATA of byte 2 -> o_tx=1, o_busy=0 the next cycle. A new done edge afterwards yields a complete correct frame.
6. Done edge on the first IDLE cycle after o_sent -> accepted; new frame starts; o_overrun=0.
